srt_radix2_core: RTL and testbench
==================================

// Module: srt_radix2_core
// PURPOSE
//  Iterative radix-2 SRT mantissa divider; sits directly downstream of the normalizer.
//  Consumes the normalized 25-bit dividend/divisor mantissas plus the exponent and sign.
//  Produces an unrounded quotient, a sticky bit and special-case flags for the rounding stage.
//  One quotient digit {-1,0,+1} per cycle, on-the-fly conversion, negative-remainder correction.
// PARAMETERS
//  MANT_W  25          normalized mantissa width: bit24=0 guard, bit23=hidden 1, bits22:0 frac
//  EXP_W   8           exponent width, passed through untouched
//  ITERS   MANT_W+2    quotient digits generated = quotient width Q_W (27)
// PORTS
//  clk                 in   1       single clock, rising edge
//  rst                 in   1       synchronous, active-high reset
//  in_valid            in   1       operands valid
//  in_ready            out  1       core idle, can accept
//  dividend_mant       in   MANT_W  normalized dividend mantissa
//  divisor_mant        in   MANT_W  normalized divisor mantissa
//  exp_in              in   EXP_W   current_exponent from normalizer
//  sign_in             in   1       result_sign from normalizer
//  out_valid           out  1       result valid, held until out_ready
//  out_ready           in   1       downstream accepts
//  quotient            out  ITERS   q fraction, weights 2^-1..2^-ITERS, q in (0.25,1)
//  sticky              out  1       final remainder != 0
//  div_by_zero         out  1       divisor_mant[23]==0
//  zero_dividend       out  1       dividend_mant[23]==0 (and divisor nonzero)
//  exp_out / sign_out  out  EXP_W/1 registered copies of exp_in / sign_in
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0, quotient=0, sticky=0, flags=0, exp_out=0, sign_out=0.
//  Reset asserted mid-iteration aborts the operation; no partial result ever appears.
//  Accept when in_valid & in_ready; all inputs captured that edge; in_ready=0 until back in IDLE.
//  Scaling: x = dividend_mant (25 frac bits, x in [0.25,0.5)); d = divisor_mant<<1 (d in [0.5,1)).
//  Remainder r: MANT_W+2 = 27-bit two's complement, 25 frac bits; r0 = x; |r| <= d always.
//  Digit select (sub-module) on top 4 bits of 2r (sign,int,2 frac):
//   2r >= +0.5 -> +1, r' = 2r-d;  2r < -0.5 -> -1, r' = 2r+d;  else 0, r' = 2r.
//  On-the-fly: Q,QM regs (ITERS bits): +1: Q={Q,1},QM={Q,0}; 0: Q={Q,0},QM={QM,1}; -1: Q={QM,1},QM={QM,0}.
//  FSM: IDLE -(accept, both nonzero)-> ITER; ITER runs exactly ITERS cycles (down-counter) -> FIX;
//   FIX: if r<0 then quotient=QM... i.e. Q-1ulp and r+=d; sticky=(r_corrected!=0) -> DONE.
//   IDLE -(accept, div_by_zero or zero_dividend)-> DONE directly, quotient=0, sticky=0.
//   DONE: out_valid=1, outputs stable; out_valid & out_ready -> IDLE (in_ready=1 next cycle).
//  Latency accept->out_valid: ITERS+2 = 29 cycles normal, 1 cycle special case.
//  Both flags high when both mantissas zero: div_by_zero has priority, zero_dividend=0.
//  No back-to-back overlap: throughput one op per ITERS+3 cycles minimum.
// STRUCTURE
//  Package srt_pkg: state_e {IDLE,ITER,FIX,DONE}; digit_e {NEG=2'b11,ZERO=2'b00,POS=2'b01};
//   MANT_W/EXP_W/ITERS defaults; REM_W = MANT_W+2.
//  Sub-module srt_qds: combinational 4-bit remainder estimate -> digit_e.
//  Datapath (r, Q, QM, counter) and FSM stay in this module.
// TESTING
//  1. 1.0/1.0: 25'h0800000 / 25'h0800000 -> quotient=27'h4000000, sticky=0, out_valid 29 cyc after accept.
//  2. 1.5/1.0: 25'h0C00000 / 25'h0800000 -> quotient=27'h6000000, sticky=0.
//  3. 1.0/1.5: 25'h0800000 / 25'h0C00000 -> quotient=27'h2AAAAAA, sticky=1 (exercises -1 digits + FIX).
//  4. divisor 0: any / 25'h0 -> div_by_zero=1, quotient=0, out_valid 1 cycle after accept;
//     0/0 -> div_by_zero=1, zero_dividend=0.
//  5. Backpressure: out_ready=0 for 10 cycles -> outputs stable, in_ready=0; new in_valid ignored.
//  6. rst pulsed at iteration 10 -> next cycle IDLE, in_ready=1, out_valid=0; next op result correct.
//  Scoreboard: random mantissas vs (x<<ITERS)/d integer model, quotient and sticky exact.

Source files
------------

// File: rtl/srt_pkg.sv
// ----------------------------------------------------------------------------
// srt_pkg
//   Shared types and default sizes for the radix-2 SRT mantissa divider.
//   state_e : control FSM states of srt_radix2_core
//   digit_e : redundant quotient digit {-1,0,+1} as a 2-bit code
// ----------------------------------------------------------------------------
package srt_pkg;

    localparam int DEF_MANT_W = 25;              // guard + hidden + 23 fraction bits
    localparam int DEF_EXP_W  = 8;
    localparam int DEF_ITERS  = DEF_MANT_W + 2;  // quotient digits produced
    localparam int DEF_REM_W  = DEF_MANT_W + 2;  // two's complement partial remainder

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        ZERO = 2'b00,
        POS  = 2'b01,
        NEG  = 2'b11
    } digit_e;

endpackage

// File: rtl/srt_qds.sv
// ----------------------------------------------------------------------------
// srt_qds
//   Radix-2 SRT quotient digit selection.
//   Ports:
//     est_i   in  4  truncated 2r estimate: sign, integer, two fraction bits
//                    (value = est_i / 4)
//     digit_o out 2  selected digit (digit_e)
//   Truncation makes est_i <= 2r < est_i + 0.25, so the thresholds below
//   keep the next remainder inside [-d, d).
// ----------------------------------------------------------------------------
module srt_qds
    import srt_pkg::*;
(
    input  logic signed [3:0] est_i,
    output digit_e            digit_o
);

    always_comb begin
        digit_o = ZERO;
        if (est_i >= 4'sd2) begin           // 2r >= +0.5
            digit_o = POS;
        end else if (est_i <= -4'sd3) begin // 2r <  -0.5
            digit_o = NEG;
        end
    end

endmodule

// File: rtl/srt_radix2_core.sv
// ----------------------------------------------------------------------------
// srt_radix2_core
//   Iterative radix-2 SRT mantissa divider with on-the-fly quotient
//   conversion and a final negative-remainder correction step.
//   Ports:
//     clk, rst                  clock, synchronous active-high reset
//     in_valid / in_ready       operand handshake (in_ready = core idle)
//     dividend_mant             normalized dividend mantissa (bit MANT_W-2 hidden)
//     divisor_mant              normalized divisor mantissa
//     exp_in, sign_in           passed through to exp_out / sign_out
//     out_valid / out_ready     result handshake, result held until taken
//     quotient                  unrounded quotient, weights 2^-1 .. 2^-ITERS
//     sticky                    final remainder nonzero
//     div_by_zero               divisor hidden bit clear
//     zero_dividend             dividend hidden bit clear, divisor nonzero
// ----------------------------------------------------------------------------
module srt_radix2_core
    import srt_pkg::*;
#(
    parameter int MANT_W = DEF_MANT_W,
    parameter int EXP_W  = DEF_EXP_W,
    parameter int ITERS  = MANT_W + 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W-1:0] dividend_mant,
    input  logic [MANT_W-1:0] divisor_mant,
    input  logic [EXP_W-1:0]  exp_in,
    input  logic              sign_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ITERS-1:0]  quotient,
    output logic              sticky,
    output logic              div_by_zero,
    output logic              zero_dividend,
    output logic [EXP_W-1:0]  exp_out,
    output logic              sign_out
);

    localparam int REM_W = MANT_W + 2;
    localparam int CNT_W = $clog2(ITERS + 1);
    localparam int HID   = MANT_W - 2;

    state_e                   state_q, state_d;
    logic signed [REM_W-1:0]  rem_q, rem_d;
    logic signed [REM_W-1:0]  div_q, div_d;
    logic [ITERS-1:0]         qp_q, qp_d;     // on-the-fly Q
    logic [ITERS-1:0]         qm_q, qm_d;     // on-the-fly Q - 1ulp
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [ITERS-1:0]         quot_q, quot_d;
    logic                     sticky_q, sticky_d;
    logic                     dbz_q, dbz_d;
    logic                     zd_q, zd_d;
    logic [EXP_W-1:0]         exp_q, exp_d;
    logic                     sign_q, sign_d;

    logic signed [REM_W-1:0]  rem2;
    logic signed [REM_W-1:0]  rem_step;
    logic signed [REM_W-1:0]  rem_fix;
    logic signed [3:0]        est;
    digit_e                   digit;

    // |r| <= d < 1, so 2r stays inside the [-2,2) range of the remainder format.
    assign rem2    = rem_q <<< 1;
    assign est     = rem2[REM_W-1 -: 4];
    assign rem_fix = rem_q + div_q;

    srt_qds u_qds (
        .est_i   (est),
        .digit_o (digit)
    );

    always_comb begin
        rem_step = rem2;
        case (digit)
            POS:     rem_step = rem2 - div_q;
            NEG:     rem_step = rem2 + div_q;
            default: rem_step = rem2;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        div_d    = div_q;
        qp_d     = qp_q;
        qm_d     = qm_q;
        cnt_d    = cnt_q;
        quot_d   = quot_q;
        sticky_d = sticky_q;
        dbz_d    = dbz_q;
        zd_d     = zd_q;
        exp_d    = exp_q;
        sign_d   = sign_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    exp_d  = exp_in;
                    sign_d = sign_in;
                    if (!divisor_mant[HID]) begin
                        // divide-by-zero wins over a zero dividend
                        dbz_d    = 1'b1;
                        zd_d     = 1'b0;
                        quot_d   = '0;
                        sticky_d = 1'b0;
                        state_d  = DONE;
                    end else if (!dividend_mant[HID]) begin
                        dbz_d    = 1'b0;
                        zd_d     = 1'b1;
                        quot_d   = '0;
                        sticky_d = 1'b0;
                        state_d  = DONE;
                    end else begin
                        dbz_d   = 1'b0;
                        zd_d    = 1'b0;
                        // x in [0.25,0.5), d = divisor<<1 in [0.5,1), 25 fraction bits
                        rem_d   = $signed({2'b00, dividend_mant});
                        div_d   = $signed({1'b0, divisor_mant, 1'b0});
                        qp_d    = '0;
                        qm_d    = '1;
                        cnt_d   = CNT_W'(ITERS - 1);
                        state_d = ITER;
                    end
                end
            end
            ITER: begin
                rem_d = rem_step;
                case (digit)
                    POS: begin
                        qp_d = {qp_q[ITERS-2:0], 1'b1};
                        qm_d = {qp_q[ITERS-2:0], 1'b0};
                    end
                    NEG: begin
                        qp_d = {qm_q[ITERS-2:0], 1'b1};
                        qm_d = {qm_q[ITERS-2:0], 1'b0};
                    end
                    default: begin
                        qp_d = {qp_q[ITERS-2:0], 1'b0};
                        qm_d = {qm_q[ITERS-2:0], 1'b1};
                    end
                endcase
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FIX: begin
                // a negative final remainder means the quotient overshot by one ulp
                if (rem_q[REM_W-1]) begin
                    quot_d   = qm_q;
                    rem_d    = rem_fix;
                    sticky_d = (rem_fix != '0);
                end else begin
                    quot_d   = qp_q;
                    sticky_d = (rem_q != '0);
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            quot_q   <= '0;
            sticky_q <= 1'b0;
            dbz_q    <= 1'b0;
            zd_q     <= 1'b0;
            exp_q    <= '0;
            sign_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            quot_q   <= quot_d;
            sticky_q <= sticky_d;
            dbz_q    <= dbz_d;
            zd_q     <= zd_d;
            exp_q    <= exp_d;
            sign_q   <= sign_d;
        end
        rem_q <= rem_d;
        div_q <= div_d;
        qp_q  <= qp_d;
        qm_q  <= qm_d;
        cnt_q <= cnt_d;
    end

    assign in_ready      = (state_q == IDLE);
    assign out_valid     = (state_q == DONE);
    assign quotient      = quot_q;
    assign sticky        = sticky_q;
    assign div_by_zero   = dbz_q;
    assign zero_dividend = zd_q;
    assign exp_out       = exp_q;
    assign sign_out      = sign_q;

endmodule

// File: tb/tb_srt_radix2_core.sv
module tb_srt_radix2_core;

    localparam int MANT_W = 25;
    localparam int EXP_W  = 8;
    localparam int ITERS  = MANT_W + 2;
    localparam int LAT_NORMAL  = ITERS + 2;
    localparam int LAT_SPECIAL = 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [MANT_W-1:0] dividend_mant;
    logic [MANT_W-1:0] divisor_mant;
    logic [EXP_W-1:0]  exp_in;
    logic              sign_in;
    logic              out_valid;
    logic              out_ready;
    logic [ITERS-1:0]  quotient;
    logic              sticky;
    logic              div_by_zero;
    logic              zero_dividend;
    logic [EXP_W-1:0]  exp_out;
    logic              sign_out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    srt_radix2_core #(
        .MANT_W (MANT_W),
        .EXP_W  (EXP_W),
        .ITERS  (ITERS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .dividend_mant (dividend_mant),
        .divisor_mant  (divisor_mant),
        .exp_in        (exp_in),
        .sign_in       (sign_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .quotient      (quotient),
        .sticky        (sticky),
        .div_by_zero   (div_by_zero),
        .zero_dividend (zero_dividend),
        .exp_out       (exp_out),
        .sign_out      (sign_out)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present operands for one cycle; returns #1 after the accepting edge.
    task automatic start_op(input string tag, input logic [MANT_W-1:0] dm,
                            input logic [MANT_W-1:0] dv, input logic [EXP_W-1:0] e,
                            input logic s);
        @(negedge clk);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        dividend_mant = dm;
        divisor_mant  = dv;
        exp_in        = e;
        sign_in       = s;
        in_valid      = 1'b1;
        @(posedge clk);
        #1;
        in_valid      = 1'b0;
        dividend_mant = 25'h1A5A5A5;
        divisor_mant  = 25'h0F0F0F0;
        exp_in        = ~e;
        sign_in       = ~s;
    endtask

    // Latency counts the accept cycle as cycle 0; bounded wait.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic finish_op(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_ready_after"}, 64'(in_ready), 64'd1);
        chk({tag, "_valid_after"}, 64'(out_valid), 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [MANT_W-1:0] dm,
                          input logic [MANT_W-1:0] dv, input logic [EXP_W-1:0] e,
                          input logic s, input logic [ITERS-1:0] eq, input logic es,
                          input logic edbz, input logic ezd, input int elat);
        int lat;
        start_op(tag, dm, dv, e, s);
        wait_valid(lat);
        chk({tag, "_lat"},    64'(lat),           64'(elat));
        chk({tag, "_q"},      64'(quotient),      64'(eq));
        chk({tag, "_sticky"}, 64'(sticky),        64'(es));
        chk({tag, "_dbz"},    64'(div_by_zero),   64'(edbz));
        chk({tag, "_zd"},     64'(zero_dividend), 64'(ezd));
        chk({tag, "_exp"},    64'(exp_out),       64'(e));
        chk({tag, "_sign"},   64'(sign_out),      64'(s));
        finish_op(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [MANT_W-1:0] dm, dv;
        logic [63:0]       num, den;
        logic [ITERS-1:0]  hold_q;
        int                lat;

        rst           = 1'b1;
        in_valid      = 1'b0;
        out_ready     = 1'b0;
        dividend_mant = '0;
        divisor_mant  = '0;
        exp_in        = '0;
        sign_in       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_in_ready",  64'(in_ready),      64'd1);
        chk("rst_out_valid", 64'(out_valid),     64'd0);
        chk("rst_quotient",  64'(quotient),      64'd0);
        chk("rst_sticky",    64'(sticky),        64'd0);
        chk("rst_dbz",       64'(div_by_zero),   64'd0);
        chk("rst_zd",        64'(zero_dividend), 64'd0);
        chk("rst_exp",       64'(exp_out),       64'd0);
        chk("rst_sign",      64'(sign_out),      64'd0);

        // Directed vectors
        run_op("one_one",   25'h0800000, 25'h0800000, 8'h7F, 1'b0, 27'h4000000, 1'b0, 1'b0, 1'b0, LAT_NORMAL);
        run_op("1p5_one",   25'h0C00000, 25'h0800000, 8'h80, 1'b1, 27'h6000000, 1'b0, 1'b0, 1'b0, LAT_NORMAL);
        run_op("one_1p5",   25'h0800000, 25'h0C00000, 8'h3C, 1'b0, 27'h2AAAAAA, 1'b1, 1'b0, 1'b0, LAT_NORMAL);
        run_op("max_min",   25'h0FFFFFF, 25'h0800000, 8'h01, 1'b1, 27'h7FFFFF8, 1'b0, 1'b0, 1'b0, LAT_NORMAL);
        run_op("div_zero",  25'h0900000, 25'h0000000, 8'hAA, 1'b1, 27'h0,       1'b0, 1'b1, 1'b0, LAT_SPECIAL);
        run_op("zero_zero", 25'h0000000, 25'h0000000, 8'h55, 1'b0, 27'h0,       1'b0, 1'b1, 1'b0, LAT_SPECIAL);
        run_op("zero_div",  25'h0000000, 25'h0A00000, 8'hC3, 1'b1, 27'h0,       1'b0, 1'b0, 1'b1, LAT_SPECIAL);

        // Backpressure: result held, new requests ignored
        start_op("bp", 25'h0800000, 25'h0C00000, 8'h42, 1'b1);
        wait_valid(lat);
        chk("bp_lat", 64'(lat), 64'(LAT_NORMAL));
        hold_q = quotient;
        chk("bp_q", 64'(hold_q), 64'h2AAAAAA);
        for (int i = 0; i < 10; i++) begin
            dividend_mant = 25'h0C00000;
            divisor_mant  = 25'h0800000;
            in_valid      = 1'b1;
            @(posedge clk);
            #1;
            chk("bp_hold_valid", 64'(out_valid), 64'd1);
            chk("bp_hold_ready", 64'(in_ready),  64'd0);
            chk("bp_hold_q",     64'(quotient),  64'h2AAAAAA);
            chk("bp_hold_st",    64'(sticky),    64'd1);
            chk("bp_hold_exp",   64'(exp_out),   64'h42);
        end
        in_valid = 1'b0;
        finish_op("bp");
        @(posedge clk);
        #1;
        chk("bp_no_stray_op", 64'(in_ready), 64'd1);

        // Reset during iteration aborts the operation
        start_op("rstmid", 25'h0C00000, 25'h0800000, 8'h11, 1'b1);
        repeat (9) @(posedge clk);
        #1;
        chk("rstmid_busy", 64'(in_ready), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rstmid_ready", 64'(in_ready),  64'd1);
        chk("rstmid_valid", 64'(out_valid), 64'd0);
        chk("rstmid_q",     64'(quotient),  64'd0);
        chk("rstmid_exp",   64'(exp_out),   64'd0);
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            chk("rstmid_quiet", 64'(out_valid), 64'd0);
        end
        run_op("after_rst", 25'h0800000, 25'h0C00000, 8'h22, 1'b0, 27'h2AAAAAA, 1'b1, 1'b0, 1'b0, LAT_NORMAL);

        // Random operands against an integer division model
        for (int i = 0; i < 24; i++) begin
            dm  = 25'h0800000 | 25'($urandom & 32'h007FFFFF);
            dv  = 25'h0800000 | 25'($urandom & 32'h007FFFFF);
            num = 64'(dm) << ITERS;
            den = 64'(dv) << 1;
            run_op("rand", dm, dv, 8'($urandom), 1'($urandom),
                   27'(num / den), ((num % den) != 64'd0), 1'b0, 1'b0, LAT_NORMAL);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
